// File: rtl/jt_sfg_busif.sv
// SFG cartridge slot front end: strobe sync, window decode,
// single-cycle device pulses and wait-state generation.
module jt_sfg_busif #(
  parameter int ID_LEN = 6,
  parameter logic [8*ID_LEN-1:0] ID_STR = "MCHFM0",
  parameter logic [13:0] ID_BASE = 14'h3F80,
  parameter logic [13:0] DEV_BASE = 14'h3FF0,
  parameter int DEV_N = 1,
  parameter int WAIT_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slt_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [13:0]        addr,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               dout_oe,
  output logic               wait_n,
  output logic [DEV_N-1:0]   dev_cs,
  output logic               dev_a0,
  output logic               dev_wr,
  output logic               dev_rd,
  output logic [7:0]         dev_din,
  input  logic [8*DEV_N-1:0] dev_dout,
  input  logic [DEV_N-1:0]   dev_busy
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, HOLD, RELEASE
  } state_t;

  state_t state, state_nx;

  logic [2:0] rd_q, wr_q, slt_q;
  logic rd_s, wr_s, slt_s;
  logic rd_fall, wr_fall, rd_rise, wr_rise;
  logic evt, both_low;

  logic id_hit;
  logic [DEV_N-1:0] hit_v;

  logic [DEV_N-1:0] sel;
  logic id_acc, is_rd, first, a0_q;
  logic [3:0] off_q, cnt;
  logic [7:0] dout_r, din_r;
  logic [7:0] id_byte, dev_rdata;
  logic busy_sel, go_acc;

  // Strobes reset to "low" so RELEASE waits for a genuinely high bus
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 3'b000;
      wr_q  <= 3'b000;
      slt_q <= 3'b111;
    end else begin
      rd_q  <= {rd_q[1:0], rd_n};
      wr_q  <= {wr_q[1:0], wr_n};
      slt_q <= {slt_q[1:0], slt_n};
    end
  end

  assign rd_s     = rd_q[1];
  assign wr_s     = wr_q[1];
  assign slt_s    = slt_q[1];
  assign rd_fall  = rd_q[2] & ~rd_s;
  assign wr_fall  = wr_q[2] & ~wr_s;
  assign rd_rise  = ~rd_q[2] & rd_s;
  assign wr_rise  = ~wr_q[2] & wr_s;
  assign evt      = (rd_fall | wr_fall) & ~slt_s;
  assign both_low = ~rd_s & ~wr_s;

  always_comb begin
    id_hit = (addr >= ID_BASE) &&
             (addr <= ID_BASE + 14'd15);
    for (int k = 0; k < DEV_N; k++)
      hit_v[k] = addr[13:1] ==
                 DEV_BASE[13:1] + 13'(k);
  end

  always_comb begin
    id_byte = 8'h00;
    for (int i = 0; i < ID_LEN; i++)
      if (off_q == 4'(i))
        id_byte = ID_STR[8*(ID_LEN-1-i) +: 8];
  end

  always_comb begin
    dev_rdata = 8'h00;
    for (int k = 0; k < DEV_N; k++)
      if (sel[k])
        dev_rdata = dev_rdata | dev_dout[8*k +: 8];
  end

  assign busy_sel = |(dev_busy & sel);
  assign go_acc   = evt & ~both_low &
                    ((|hit_v) | (id_hit & ~rd_s));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (evt)
          state_nx = go_acc ? ACCESS : RELEASE;
      ACCESS:
        if (id_acc || (cnt == 4'd0 && !busy_sel))
          state_nx = HOLD;
      HOLD:
        if (is_rd ? rd_rise : wr_rise)
          state_nx = IDLE;
      RELEASE:
        if (rd_s && wr_s)
          state_nx = IDLE;
      default:
        state_nx = RELEASE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RELEASE;
      sel    <= '0;
      id_acc <= 1'b0;
      is_rd  <= 1'b0;
      first  <= 1'b0;
      a0_q   <= 1'b0;
      off_q  <= 4'd0;
      cnt    <= 4'd0;
      dout_r <= 8'h00;
      din_r  <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == IDLE && go_acc) begin
        sel    <= hit_v;
        id_acc <= ~|hit_v;
        is_rd  <= ~rd_s;
        first  <= 1'b1;
        a0_q   <= addr[0];
        off_q  <= 4'(addr - ID_BASE);
        cnt    <= 4'(WAIT_CYC - 1);
        if (rd_s)
          din_r <= din;
      end
      if (state == ACCESS) begin
        first <= 1'b0;
        if (cnt != 4'd0)
          cnt <= cnt - 4'd1;
        if (state_nx == HOLD && is_rd)
          dout_r <= id_acc ? id_byte : dev_rdata;
      end
    end
  end

  assign dev_cs  = (state == ACCESS || state == HOLD) ?
                   sel : '0;
  assign dev_a0  = a0_q;
  assign dev_din = din_r;
  assign dev_wr  = (state == ACCESS) & first &
                   ~id_acc & ~is_rd;
  assign dev_rd  = (state == ACCESS) & first &
                   ~id_acc & is_rd;
  assign wait_n  = ~((state == ACCESS) & ~id_acc);
  assign dout_oe = (state == HOLD) & is_rd;
  assign dout    = dout_r;

endmodule

// File: tb/tb_jt_sfg_busif.sv
// Directed bench for jt_sfg_busif: ID reads, device
// accesses, busy stretch, ignored accesses and reset.
module tb_jt_sfg_busif;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slt_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [13:0] addr = 14'h0;
  logic [7:0]  din = 8'h0;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        wait_n;
  logic [1:0]  dev_cs;
  logic        dev_a0;
  logic        dev_wr;
  logic        dev_rd;
  logic [7:0]  dev_din;
  logic [15:0] dev_dout = 16'hA53C;
  logic [1:0]  dev_busy = 2'b00;

  int checks = 0;
  int errors = 0;

  int n_wait, n_wr, n_rd, n_oe, n_oe_rel, bcnt;
  bit rel, arm;
  logic [1:0] p_cs;
  logic       p_a0;
  logic [7:0] p_din, o_dout;

  always #5 clk = ~clk;

  jt_sfg_busif #(
    .DEV_N(2),
    .WAIT_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .slt_n(slt_n),
    .rd_n(rd_n), .wr_n(wr_n), .addr(addr),
    .din(din), .dout(dout), .dout_oe(dout_oe),
    .wait_n(wait_n), .dev_cs(dev_cs),
    .dev_a0(dev_a0), .dev_wr(dev_wr),
    .dev_rd(dev_rd), .dev_din(dev_din),
    .dev_dout(dev_dout), .dev_busy(dev_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_wait = 0; n_wr = 0; n_rd = 0;
    n_oe = 0; n_oe_rel = 0; bcnt = 0;
    rel = 0; arm = 0;
    p_cs = 2'b00; p_a0 = 1'b0;
    p_din = 8'h00; o_dout = 8'h00;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
    if (!wait_n) n_wait++;
    if (dev_wr) n_wr++;
    if (dev_rd) n_rd++;
    if (dout_oe) begin
      o_dout = dout;
      if (rel) n_oe_rel++;
      else n_oe++;
    end
    if (dev_wr || dev_rd) begin
      p_cs = dev_cs;
      p_a0 = dev_a0;
      p_din = dev_din;
    end
    if (arm && (dev_wr || dev_rd)) bcnt = 1;
    else if (bcnt > 0) bcnt++;
    if (bcnt == 5) begin
      dev_busy = 2'b00;
      bcnt = 0;
    end
  endtask

  task automatic access(input bit wr,
                        input logic [13:0] a,
                        input logic [7:0] d,
                        input bit sel,
                        input bit both);
    clr();
    if (dev_busy != 2'b00) arm = 1;
    slt_n = ~sel;
    addr = a;
    din = d;
    if (wr || both) wr_n = 1'b0;
    if (!wr || both) rd_n = 1'b0;
    repeat (12) sample();
    rel = 1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (6) sample();
    rel = 0;
    slt_n = 1'b1;
  endtask

  initial begin
    logic [47:0] id_exp;
    id_exp = 48'h4D_43_48_46_4D_30;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_n", wait_n, 1);
    chk("rst_oe", dout_oe, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_cs", dev_cs, 0);
    chk("rst_pulse", {dev_wr, dev_rd}, 0);
    chk("rst_a0_din", {dev_a0, dev_din}, 0);
    rst = 1'b0;
    clr();
    repeat (5) sample();

    for (int i = 0; i < 6; i++) begin
      access(0, 14'h3F80 + 14'(i), 8'h00, 1, 0);
      chk("id_byte", o_dout,
          id_exp[8*(5-i) +: 8]);
      chk("id_wait", n_wait, 0);
      chk("id_oe_rel", n_oe_rel, 2);
      chk("id_pulse", n_wr + n_rd, 0);
    end
    access(0, 14'h3F8A, 8'h00, 1, 0);
    chk("id_pad", o_dout, 8'h00);
    chk("id_pad_oe", n_oe, 9);

    access(1, 14'h3FF0, 8'h28, 1, 0);
    chk("wr_pulse", n_wr, 1);
    chk("wr_rdp", n_rd, 0);
    chk("wr_cs", p_cs, 2'b01);
    chk("wr_a0", p_a0, 0);
    chk("wr_din", p_din, 8'h28);
    chk("wr_wait", n_wait, 2);
    chk("wr_oe", n_oe + n_oe_rel, 0);

    dev_busy = 2'b10;
    access(0, 14'h3FF3, 8'h00, 1, 0);
    chk("busy_rd", n_rd, 1);
    chk("busy_cs", p_cs, 2'b10);
    chk("busy_a0", p_a0, 1);
    chk("busy_wait", n_wait, 5);
    chk("busy_dout", o_dout, 8'hA5);
    chk("busy_oe_rel", n_oe_rel, 2);
    dev_busy = 2'b00;

    access(1, 14'h1234, 8'h11, 1, 0);
    chk("unm_wr", {n_wr, n_rd, n_wait, n_oe}, 0);
    access(0, 14'h1234, 8'h00, 1, 0);
    chk("unm_rd", {n_wr, n_rd, n_wait, n_oe}, 0);
    access(1, 14'h3FF0, 8'h77, 0, 0);
    chk("noslt_wr", {n_wr, n_rd, n_wait, n_oe}, 0);
    access(0, 14'h3F80, 8'h00, 0, 0);
    chk("noslt_rd", {n_wr, n_rd, n_wait, n_oe}, 0);
    access(1, 14'h3F80, 8'h99, 1, 0);
    chk("id_write", {n_wr, n_rd, n_wait, n_oe}, 0);

    access(1, 14'h3FF0, 8'h33, 1, 1);
    chk("both_low", {n_wr, n_rd, n_wait, n_oe}, 0);
    access(1, 14'h3FF1, 8'h5A, 1, 0);
    chk("after_both", n_wr, 1);
    chk("after_both_cs", p_cs, 2'b01);
    chk("after_both_a0", p_a0, 1);
    chk("after_both_din", p_din, 8'h5A);
    chk("after_both_wait", n_wait, 2);

    clr();
    dev_busy = 2'b10;
    slt_n = 1'b0;
    addr = 14'h3FF3;
    rd_n = 1'b0;
    repeat (8) sample();
    chk("rst_mid_wait", n_wait, 6);
    chk("rst_mid_rd", n_rd, 1);
    rst = 1'b1;
    sample();
    chk("rst_mid_wait_n", wait_n, 1);
    chk("rst_mid_oe", dout_oe, 0);
    rst = 1'b0;
    clr();
    repeat (10) sample();
    chk("rst_stuck", {n_wr, n_rd, n_wait, n_oe}, 0);
    dev_busy = 2'b00;
    rd_n = 1'b1;
    slt_n = 1'b1;
    repeat (6) sample();
    access(0, 14'h3FF3, 8'h00, 1, 0);
    chk("rst_retry_rd", n_rd, 1);
    chk("rst_retry_wait", n_wait, 2);
    chk("rst_retry_dout", o_dout, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt_sfg_busif.md
# jt_sfg_busif

Parametrised cartridge-slot bus interface for the SFG family of sound cartridges. It synchronises the asynchronous slot strobes to the core clock and decodes a configurable ID-ROM window plus up to four 2-byte device windows. It generates single-cycle device read and write pulses and holds the host with `wait_n` until the addressed device is ready. It sits between the slot connector and the sound cores (jt51 and successors) and replaces fixed-address glue with a clocked, wait-capable front end.

## Interface
- `ID_LEN`, 6: number of ID bytes, 1..16.
- `ID_STR`, "MCHFM0": ID bytes, 8*`ID_LEN` bits. The first character sits at offset 0.
- `ID_BASE`, 14'h3F80: base of the ID window. The window is 16 bytes, offsets 0..15.
- `DEV_BASE`, 14'h3FF0: base of the device windows. Device k occupies `DEV_BASE`+2k (a0=0) and `DEV_BASE`+2k+1 (a0=1).
- `DEV_N`, 1: number of devices, 1..4.
- `WAIT_CYC`, 2: minimum wait cycles on any device access, 1..15.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `slt_n` in 1: slot select, asynchronous, active low.
- `rd_n` in 1: host read strobe, asynchronous, active low.
- `wr_n` in 1: host write strobe, asynchronous, active low.
- `addr` in 14: host address. Stable while a strobe is low.
- `din` in 8: host write data. Stable while `wr_n` is low.
- `dout` out 8: host read data.
- `dout_oe` out 1: drive enable for the top-level tristate.
- `wait_n` out 1: host wait request, active low.
- `dev_cs` out `DEV_N`: one-hot device select.
- `dev_a0` out 1: register/data select for the selected device.
- `dev_wr` out 1: single-cycle write pulse.
- `dev_rd` out 1: single-cycle read pulse.
- `dev_din` out 8: latched write data.
- `dev_dout` in 8*`DEV_N`: device read data. Device k uses bits [8k+7:8k].
- `dev_busy` in `DEV_N`: device k is not ready. Extends the wait.

## Operation
- Synchronisation: `rd_n`, `wr_n` and `slt_n` each pass through two flops, then a third flop for edge detection.
- Access event: a synchronised falling edge of `rd_n` or `wr_n` while synchronised `slt_n`=0.
  - Both strobes low at the event: invalid, no action.
  - Edge while `slt_n`=1: ignored.
- On an event, latch `addr` and `din`, then decode:
  - ID window: `addr` in [`ID_BASE`, `ID_BASE`+15].
  - Device k: `addr`>>1 equals (`DEV_BASE`>>1)+k, k<`DEV_N`.
  - Otherwise unmapped.
- FSM states: IDLE, ACCESS, HOLD, RELEASE.
- IDLE: on an event, go to ACCESS for device hits or ID reads. Go to RELEASE for unmapped accesses and ID writes; these produce no output activity.
- ACCESS, device:
  - First cycle: pulse `dev_rd` or `dev_wr` with `dev_cs`[k], `dev_a0`=addr[0] and `dev_din`.
  - `wait_n`=0. A 4-bit counter loads `WAIT_CYC`-1 and decrements each cycle.
  - Leave when counter=0 and `dev_busy`[k]=0. For reads, capture `dev_dout`[k] into `dout` on that cycle. Go to HOLD.
- ACCESS, ID read:
  - `dout` = ID byte at offset addr-`ID_BASE`; offsets ≥ `ID_LEN` read 8'h00.
  - No wait. Go to HOLD next cycle.
- HOLD: `wait_n`=1. `dout_oe`=1 for reads only. `dev_cs` stays asserted. Leave on synchronised rise of the active strobe, going to IDLE.
- RELEASE: wait for both synchronised strobes high, then go to IDLE.
- `dev_busy` sticking high holds `wait_n` low indefinitely. There is no timeout; the host watchdog owns that case.

## Timing
- Reset values: `wait_n`=1, `dout_oe`=0, `dout`=8'h00, `dev_cs`=0, `dev_wr`=0, `dev_rd`=0, `dev_a0`=0, `dev_din`=0. FSM in RELEASE.
- Because reset enters RELEASE, a strobe already low at reset release is never serviced.
- Reset mid-access drops `wait_n` and `dout_oe` on the next edge. Any pending device pulse is not issued.
- Cycle E: event detected, 3 clk edges after the strobe falls.
- Cycle E+1: first ACCESS cycle. `wait_n` falls and the device pulse is issued.
- Device with `dev_busy`=0: `wait_n` is low for exactly `WAIT_CYC` cycles (E+1..E+`WAIT_CYC`). `dout_oe` rises at E+`WAIT_CYC`+1.
- ID read: `dout_oe`=1 and `dout` are valid at E+2. `wait_n` stays 1 throughout.
- `dout_oe` falls 3 clk edges after the strobe rises.
- `dev_wr` and `dev_rd` are never high for more than one cycle per access.

## Test plan
- Reset, then ID read, slot low, `addr`=3F80..3F85 in turn: bytes 4D 43 48 46 4D 30 on `dout`, `wait_n` never low. `addr`=3F8A reads 00.
- Write `din`=8'h28 to 3FF0 with `WAIT_CYC`=2, `dev_busy`=0: one-cycle `dev_wr`, `dev_cs`=1, `dev_a0`=0, `dev_din`=28. `wait_n` low for exactly 2 cycles.
- `DEV_N`=2, read 3FF3 with `dev_dout`[15:8]=8'hA5 and `dev_busy`[1] held high for 5 cycles: `wait_n` released one cycle after busy falls, `dout`=A5 with `dout_oe`=1.
- Unmapped access (`addr`=1234), and any access with `slt_n`=1: no `dev_*` pulse, `wait_n`=1, `dout_oe`=0.
- `rd_n` and `wr_n` low together: no pulse. After both rise, the next valid write is serviced normally.
- Assert `rst` during a busy wait: `wait_n`=1 next cycle. A still-low strobe produces no pulse until it is released and reasserted.
